// File: rtl/cfi_shadow_stack_if.sv
// Commit-port bundle and monitor status outputs of the CFI shadow stack.
// The slave side is the monitor; the master side drives commits and observes status.
interface cfi_shadow_stack_if #(
    parameter int NR_PORTS = 2,
    parameter int DEPTH    = 16,
    parameter int AW       = 64
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    logic                   arm_i;
    logic                   disarm_i;
    logic                   clear_i;
    logic [NR_PORTS-1:0]    commit_ack_i;
    logic [NR_PORTS-1:0]    commit_call_i;
    logic [NR_PORTS-1:0]    commit_ret_i;
    logic [NR_PORTS*AW-1:0] commit_link_i;
    logic [NR_PORTS*AW-1:0] commit_target_i;
    logic                   armed_o;
    logic [CW-1:0]          depth_o;
    logic                   violation_o;
    logic [1:0]             violation_cause_o;
    logic [PW-1:0]          violation_port_o;
    logic                   violation_sticky_o;

    modport slave (
        input  arm_i, disarm_i, clear_i,
        input  commit_ack_i, commit_call_i, commit_ret_i, commit_link_i, commit_target_i,
        output armed_o, depth_o, violation_o, violation_cause_o, violation_port_o,
        output violation_sticky_o
    );

    modport master (
        output arm_i, disarm_i, clear_i,
        output commit_ack_i, commit_call_i, commit_ret_i, commit_link_i, commit_target_i,
        input  armed_o, depth_o, violation_o, violation_cause_o, violation_port_o,
        input  violation_sticky_o
    );
endinterface

// File: rtl/cfi_shadow_stack.sv
// Return-address shadow stack monitoring several commit ports per cycle;
// flags mismatching returns, underflow and (optionally) overflow.
module cfi_shadow_stack #(
    parameter int NR_PORTS = 2,
    parameter int DEPTH    = 16,
    parameter int AW       = 64,
    parameter bit OVF_WRAP = 1'b1
) (
    input logic               clk_i,
    input logic               rst_i,
    cfi_shadow_stack_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PTRW = $clog2(DEPTH);
    localparam int PW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISMATCH = 2'b01;
    localparam logic [1:0] CAUSE_UNDER    = 2'b10;
    localparam logic [1:0] CAUSE_OVER     = 2'b11;

    typedef enum logic {IDLE, ARMED} state_t;

    state_t          state, state_n;
    logic [AW-1:0]   mem   [DEPTH];
    logic [AW-1:0]   mem_n [DEPTH];
    logic [PTRW-1:0] ptr, ptr_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            vio, vio_n;
    logic [1:0]      cause, cause_n;
    logic [PW-1:0]   port, port_n;
    logic            sticky, sticky_n;
    logic [1:0]      cause_p;

    // ptr is the next free slot; the top entry sits at ptr-1. When full,
    // ptr also addresses the oldest entry, so a wrapping push overwrites it.
    always_comb begin
        state_n = state;
        mem_n   = mem;
        ptr_n   = ptr;
        cnt_n   = cnt;
        vio_n   = 1'b0;
        cause_n = CAUSE_NONE;
        port_n  = '0;
        cause_p = CAUSE_NONE;
        case (state)
            IDLE: begin
                if (bus.arm_i) begin
                    state_n = ARMED;
                    ptr_n   = '0;
                    cnt_n   = '0;
                end
            end
            ARMED: begin
                if (bus.disarm_i) begin
                    state_n = IDLE;
                end
                for (int p = 0; p < NR_PORTS; p++) begin
                    cause_p = CAUSE_NONE;
                    if (bus.commit_ack_i[p]) begin
                        if (bus.commit_ret_i[p]) begin
                            if (cnt_n == '0) begin
                                cause_p = CAUSE_UNDER;
                            end else begin
                                ptr_n = ptr_n - PTRW'(1);
                                cnt_n = cnt_n - CW'(1);
                                if (mem_n[ptr_n] != bus.commit_target_i[p*AW +: AW]) begin
                                    cause_p = CAUSE_MISMATCH;
                                end
                            end
                        end
                        if (bus.commit_call_i[p]) begin
                            if (cnt_n == FULL && !OVF_WRAP) begin
                                cause_p = CAUSE_OVER;
                            end else begin
                                mem_n[ptr_n] = bus.commit_link_i[p*AW +: AW];
                                ptr_n = ptr_n + PTRW'(1);
                                if (cnt_n != FULL) begin
                                    cnt_n = cnt_n + CW'(1);
                                end
                            end
                        end
                        if (cause_p != CAUSE_NONE && !vio_n) begin
                            vio_n   = 1'b1;
                            cause_n = cause_p;
                            port_n  = PW'(p);
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        sticky_n = (sticky && !bus.clear_i) || vio_n;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            vio    <= 1'b0;
            cause  <= CAUSE_NONE;
            port   <= '0;
            sticky <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            cnt    <= cnt_n;
            vio    <= vio_n;
            cause  <= cause_n;
            port   <= port_n;
            sticky <= sticky_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mem <= mem_n;
        end
    end

    assign bus.armed_o            = (state == ARMED);
    assign bus.depth_o            = cnt;
    assign bus.violation_o        = vio;
    assign bus.violation_cause_o  = cause;
    assign bus.violation_port_o   = port;
    assign bus.violation_sticky_o = sticky;
endmodule
